// File: rtl/dec2str_pkg.sv
// rtl/dec2str_pkg.sv - shared ASCII constants, FSM states and range helper for dec2str_nd
package dec2str_pkg;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BAD   = 8'h3F;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest value printable in nd digits, clamped to the all-ones value of a w-bit word.
  function automatic logic [63:0] pow10_minus1(input int nd, input int w);
    logic [63:0] lim;
    logic [63:0] p;
    logic        sat;
    lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    p   = 64'd1;
    sat = 1'b0;
    for (int i = 0; i < nd; i++) begin
      if (p > lim / 64'd10) sat = 1'b1;
      else                  p   = p * 64'd10;
    end
    return sat ? lim : (p - 64'd1);
  endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// rtl/bcd_dd_step.sv - one double-dabble iteration: add-3 on every nibble, then shift in one bit
module bcd_dd_step #(
  parameter int ND = 5
) (
  input  logic [4*ND-1:0] bcd_i,
  input  logic            carry_i,
  output logic [4*ND-1:0] bcd_o
);

  logic [4*ND-1:0] adj;

  for (genvar i = 0; i < ND; i++) begin : g_nib
    assign adj[4*i +: 4] = (bcd_i[4*i +: 4] >= 4'd5) ? (bcd_i[4*i +: 4] + 4'd3)
                                                      : bcd_i[4*i +: 4];
  end

  // The top adjusted bit falls off: overflow is judged from the captured magnitude instead.
  assign bcd_o = {adj[4*ND-2:0], carry_i};

endmodule

// File: rtl/dec2str_nd.sv
// rtl/dec2str_nd.sv - signed integer to fixed-width ASCII string converter (sequential double-dabble)
module dec2str_nd
  import dec2str_pkg::*;
#(
  parameter int W   = 16,
  parameter int ND  = 5,
  parameter int LZB = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        N,
  output logic                out_valid,
  output logic [8*(ND+2)-1:0] STR,
  output logic                ovf
);

  localparam int              CW       = $clog2(W);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(W - 1);
  localparam logic [63:0]     MAXV64   = pow10_minus1(ND, W);
  localparam logic [W-1:0]    MAXV     = MAXV64[W-1:0];
  localparam int              SW       = 8 * (ND + 2);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [4*ND-1:0] bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic            ovfr_q, ovfr_d;
  logic [SW-1:0]   str_q, str_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    mag_in;
  logic [4*ND-1:0] bcd_step;
  logic [SW-1:0]   fmt;

  // Unsigned negate keeps -2^(W-1) exact as 2^(W-1).
  assign mag_in = N[W-1] ? (~N + 1'b1) : N;

  bcd_dd_step #(.ND(ND)) u_step (
    .bcd_i   (bcd_q),
    .carry_i (mag_q[W-1]),
    .bcd_o   (bcd_step)
  );

  always_comb begin
    logic       seen;
    logic [3:0] dig;
    fmt  = '0;
    seen = 1'b0;
    dig  = 4'd0;
    fmt[SW-1 -: 8]  = neg_q ? CH_MINUS : CH_PLUS;
    fmt[8*ND +: 8]  = CH_SPACE;
    for (int i = ND - 1; i >= 0; i--) begin
      dig = bcd_q[4*i +: 4];
      if ((LZB != 0) && !seen && (dig == 4'd0) && (i != 0)) begin
        fmt[8*i +: 8] = CH_SPACE;
      end else begin
        fmt[8*i +: 8] = CH_ZERO | {4'h0, dig};
        seen          = 1'b1;
      end
    end
    if (ovfr_q) fmt = {(ND + 2){CH_BAD}};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    ovfr_d      = ovfr_q;
    str_d       = str_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          neg_d   = N[W-1];
          mag_d   = mag_in;
          ovfr_d  = (mag_in > MAXV);
          bcd_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_step;
        mag_d = {mag_q[W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        str_d       = fmt;
        ovf_d       = ovfr_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovfr_q      <= 1'b0;
      str_q       <= {(ND + 2){CH_SPACE}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      ovfr_q      <= ovfr_d;
      str_q       <= str_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign STR       = str_q;
  assign ovf       = ovf_q;

endmodule
